// File: rtl/l2_victim_buffer.sv
// One-entry victim buffer between the L2 and the memory-side line adaptor.
// Absorbs dirty evictions in one cycle, lets misses overtake the write-back, drains when idle.
module l2_victim_buffer #(
  parameter int unsigned SOffset = 5,
  parameter int unsigned SLine   = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      l2_address_i,
  input  logic             l2_read_i,
  input  logic             l2_write_i,
  input  logic [SLine-1:0] l2_wdata_i,
  output logic [SLine-1:0] l2_rdata_o,
  output logic             l2_resp_o,
  output logic [31:0]      pmem_address_o,
  output logic             pmem_read_o,
  output logic             pmem_write_o,
  output logic [SLine-1:0] pmem_wdata_o,
  input  logic [SLine-1:0] pmem_rdata_i,
  input  logic             pmem_resp_i
);

  localparam int unsigned TagW = 32 - SOffset;

  typedef enum logic [1:0] {StIdle, StResp, StFetch, StDrain} state_e;

  state_e            state_q;
  logic              buf_valid_q;
  logic [TagW-1:0]   buf_tag_q;
  logic [SLine-1:0]  buf_data_q;
  logic [SLine-1:0]  l2_rdata_q;
  logic              l2_resp_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [31:0]       pmem_address_q;

  logic [TagW-1:0]   req_tag;
  logic              hit;
  logic              unused_offset;

  assign req_tag       = l2_address_i[31:SOffset];
  assign hit           = buf_valid_q && (req_tag == buf_tag_q);
  // Offset bits within the line carry no information at this level.
  assign unused_offset = ^l2_address_i[SOffset-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      buf_valid_q    <= 1'b0;
      buf_tag_q      <= '0;
      buf_data_q     <= '0;
      l2_rdata_q     <= '0;
      l2_resp_q      <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (l2_read_i && hit) begin
            l2_rdata_q <= buf_data_q;
            l2_resp_q  <= 1'b1;
            state_q    <= StResp;
          end else if (l2_read_i) begin
            // A miss cannot alias the held line, so it may bypass the pending write-back.
            pmem_read_q    <= 1'b1;
            pmem_address_q <= {req_tag, {SOffset{1'b0}}};
            state_q        <= StFetch;
          end else if (l2_write_i && (hit || !buf_valid_q)) begin
            buf_valid_q <= 1'b1;
            buf_tag_q   <= req_tag;
            buf_data_q  <= l2_wdata_i;
            l2_resp_q   <= 1'b1;
            state_q     <= StResp;
          end else if (l2_write_i || buf_valid_q) begin
            // Conflicting eviction or idle drain; a held write is re-evaluated afterwards.
            pmem_write_q   <= 1'b1;
            pmem_address_q <= {buf_tag_q, {SOffset{1'b0}}};
            state_q        <= StDrain;
          end
        end
        StFetch: begin
          if (pmem_resp_i) begin
            l2_rdata_q  <= pmem_rdata_i;
            pmem_read_q <= 1'b0;
            l2_resp_q   <= 1'b1;
            state_q     <= StResp;
          end
        end
        StDrain: begin
          if (pmem_resp_i) begin
            pmem_write_q <= 1'b0;
            buf_valid_q  <= 1'b0;
            state_q      <= StIdle;
          end
        end
        StResp: begin
          l2_resp_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign l2_rdata_o     = l2_rdata_q;
  assign l2_resp_o      = l2_resp_q;
  assign pmem_address_o = pmem_address_q;
  assign pmem_read_o    = pmem_read_q;
  assign pmem_write_o   = pmem_write_q;
  assign pmem_wdata_o   = buf_data_q;

endmodule

// File: tb/tb_l2_victim_buffer.sv
// Bench for l2_victim_buffer: directed scenarios then random traffic, checked against a
// line-level memory/buffer model and a randomly-delayed memory responder.
module tb_l2_victim_buffer;

  localparam int unsigned SLine = 256;
  typedef logic [SLine-1:0] line_t;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    line_t       data;
  } pmem_op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] l2_address = '0;
  logic        l2_read = 1'b0;
  logic        l2_write = 1'b0;
  line_t       l2_wdata = '0;
  line_t       l2_rdata;
  logic        l2_resp;
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  line_t       pmem_wdata;
  line_t       pmem_rdata;
  logic        pmem_resp;

  l2_victim_buffer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .l2_address_i   (l2_address),
    .l2_read_i      (l2_read),
    .l2_write_i     (l2_write),
    .l2_wdata_i     (l2_wdata),
    .l2_rdata_o     (l2_rdata),
    .l2_resp_o      (l2_resp),
    .pmem_address_o (pmem_address),
    .pmem_read_o    (pmem_read),
    .pmem_write_o   (pmem_write),
    .pmem_wdata_o   (pmem_wdata),
    .pmem_rdata_i   (pmem_rdata),
    .pmem_resp_i    (pmem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what the L2 should observe per line, plus the buffer's single entry.
  line_t      gold[bit [26:0]];
  line_t      mem[bit [26:0]];
  bit         m_valid = 1'b0;
  bit [26:0]  m_tag = '0;
  line_t      m_data = '0;

  pmem_op_t   log_q[$];
  int         resp_cyc = -1;
  int         dly_fixed = -1;
  int         dly_max = 4;

  task automatic check(input string tag, input line_t got, input line_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic line_t init_pat(input bit [26:0] l);
    logic [31:0] w;
    w = {5'b0, l} ^ 32'hC3C3_0000;
    return {8{w}};
  endfunction

  function automatic line_t mem_val(input bit [26:0] l);
    return mem.exists(l) ? mem[l] : init_pat(l);
  endfunction

  function automatic line_t gold_val(input bit [26:0] l);
    return gold.exists(l) ? gold[l] : init_pat(l);
  endfunction

  // Memory responder: answers each pmem request after a delay, logs every completed operation.
  initial begin : responder
    bit        busy;
    int        cnt;
    bit [26:0] l;
    busy = 1'b0;
    cnt = -1;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst || !(pmem_read || pmem_write)) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(dly_max, 0));
        end
        if (cnt == 0) begin
          pmem_resp = 1'b1;
          resp_cyc = cyc;
          l = pmem_address[31:5];
          if (pmem_write) begin
            mem[l] = pmem_wdata;
            log_q.push_back('{1'b1, pmem_address, pmem_wdata});
          end else begin
            pmem_rdata = mem_val(l);
            log_q.push_back('{1'b0, pmem_address, '0});
          end
          cnt = -1;
        end else if (cnt > 0) begin
          cnt--;
        end
      end
    end
  end

  task automatic pop_op(input string tag, input bit wr, input logic [31:0] addr, input line_t data);
    pmem_op_t op;
    check({tag, "_oplog"}, line_t'(log_q.size()), line_t'(1));
    if (log_q.size() > 0) begin
      op = log_q.pop_front();
      check({tag, "_opkind"}, line_t'(op.wr), line_t'(wr));
      check({tag, "_opaddr"}, line_t'(op.addr), line_t'(addr));
      if (wr) check({tag, "_opdata"}, op.data, data);
    end
    log_q.delete();
  endtask

  // One L2 request presented the cycle after the previous response (DUT is in IDLE).
  task automatic txn(input bit wr, input logic [31:0] addr, input line_t data);
    bit [26:0]   l;
    bit          hit;
    int          n, got, f_rd, f_wr;
    logic [31:0] a_rd, a_wr;
    l = addr[31:5];
    hit = m_valid && (m_tag == l);
    @(posedge clk);
    #1;
    n = cyc;
    l2_address = addr;
    l2_read = !wr;
    l2_write = wr;
    l2_wdata = wr ? data : {8{$urandom}};
    got = -1; f_rd = -1; f_wr = -1; a_rd = '0; a_wr = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("pmem_excl", line_t'(pmem_read && pmem_write), '0);
      if (pmem_read && f_rd < 0) begin f_rd = cyc; a_rd = pmem_address; end
      if (pmem_write && f_wr < 0) begin f_wr = cyc; a_wr = pmem_address; end
      if (l2_resp) begin got = cyc; break; end
    end
    check("resp_seen", line_t'(got >= 0), line_t'(1));
    if (!wr && hit) begin
      check("hit_lat", line_t'(got), line_t'(n + 1));
      check("hit_nopmem", line_t'(f_rd < 0 && f_wr < 0), line_t'(1));
      check("hit_rdata", l2_rdata, gold_val(l));
    end else if (!wr) begin
      check("miss_rd_start", line_t'(f_rd), line_t'(n + 1));
      check("miss_rd_addr", line_t'(a_rd), line_t'({l, 5'b0}));
      check("miss_no_wr", line_t'(f_wr < 0), line_t'(1));
      check("miss_lat", line_t'(got), line_t'(resp_cyc + 1));
      check("miss_rdata", l2_rdata, gold_val(l));
      pop_op("miss", 1'b0, {l, 5'b0}, '0);
    end else if (hit || !m_valid) begin
      check("absorb_lat", line_t'(got), line_t'(n + 1));
      check("absorb_nopmem", line_t'(f_rd < 0 && f_wr < 0), line_t'(1));
      m_valid = 1'b1; m_tag = l; m_data = data; gold[l] = data;
    end else begin
      check("evict_start", line_t'(f_wr), line_t'(n + 1));
      check("evict_addr", line_t'(a_wr), line_t'({m_tag, 5'b0}));
      check("evict_no_rd", line_t'(f_rd < 0), line_t'(1));
      check("evict_lat", line_t'(got), line_t'(resp_cyc + 2));
      pop_op("evict", 1'b1, {m_tag, 5'b0}, m_data);
      m_tag = l; m_data = data; gold[l] = data;
    end
  endtask

  // g idle cycles; a held line must start draining the cycle after the first idle cycle.
  task automatic idle(input int g);
    int          first, f_wr;
    bit          done, saw_rd, saw_resp;
    logic [31:0] a_wr;
    @(posedge clk);
    #1;
    l2_read = 1'b0;
    l2_write = 1'b0;
    first = cyc;
    f_wr = -1; done = 1'b0; saw_rd = 1'b0; saw_resp = 1'b0; a_wr = '0;
    if (m_valid) begin
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (pmem_read) saw_rd = 1'b1;
        if (l2_resp) saw_resp = 1'b1;
        if (pmem_write && f_wr < 0) begin
          f_wr = cyc; a_wr = pmem_address;
        end else if (!pmem_write && f_wr >= 0) begin
          done = 1'b1; break;
        end
      end
      check("drain_done", line_t'(done), line_t'(1));
      check("drain_start", line_t'(f_wr), line_t'(first + 1));
      check("drain_addr", line_t'(a_wr), line_t'({m_tag, 5'b0}));
      check("drain_quiet", line_t'(saw_rd || saw_resp), '0);
      pop_op("drain", 1'b1, {m_tag, 5'b0}, m_data);
      m_valid = 1'b0;
    end else begin
      @(negedge clk);
      check("idle_quiet", line_t'({pmem_read, pmem_write, l2_resp}), '0);
    end
    for (int i = 1; i < g; i++) begin
      @(negedge clk);
      check("idle_quiet", line_t'({pmem_read, pmem_write, l2_resp}), '0);
    end
  endtask

  initial begin : main
    logic [31:0] a;
    bit          seen;
    repeat (2) @(negedge clk);
    check("rst_rdata", l2_rdata, '0);
    check("rst_resp", line_t'(l2_resp), '0);
    check("rst_pread", line_t'(pmem_read), '0);
    check("rst_pwrite", line_t'(pmem_write), '0);
    check("rst_paddr", line_t'(pmem_address), '0);
    #2 rst = 1'b0;

    txn(1'b0, 32'h0000_1000, '0);
    // Absorb then hit, then a miss that overtakes the pending drain.
    txn(1'b1, 32'h0000_2040, {32{8'hA5}});
    txn(1'b0, 32'h0000_2050, '0);
    txn(1'b0, 32'h0000_3000, '0);
    idle(2);
    // Conflicting eviction.
    txn(1'b1, 32'h0000_2040, {32{8'h5A}});
    txn(1'b1, 32'h0000_4000, {32{8'h11}});
    idle(3);
    // Coalesce with slow memory.
    dly_fixed = 10;
    txn(1'b1, 32'h0000_2040, {32{8'h01}});
    txn(1'b1, 32'h0000_2040, {32{8'h02}});
    idle(2);
    txn(1'b0, 32'h0000_2040, '0);

    // Reset while a drain is outstanding: the held line is lost.
    txn(1'b1, 32'h0000_5000, {32{8'h77}});
    @(posedge clk);
    #1;
    l2_write = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_write) begin seen = 1'b1; break; end
    end
    check("rstdrain_started", line_t'(seen), line_t'(1));
    #2 rst = 1'b1;
    #1;
    check("rstdrain_pwrite", line_t'(pmem_write), '0);
    check("rstdrain_pread", line_t'(pmem_read), '0);
    check("rstdrain_resp", line_t'(l2_resp), '0);
    check("rstdrain_paddr", line_t'(pmem_address), '0);
    check("rstdrain_rdata", l2_rdata, '0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    log_q.delete();
    m_valid = 1'b0;
    gold[27'h280] = mem_val(27'h280);
    dly_fixed = -1;
    txn(1'b0, 32'h0000_5000, '0);

    for (int t = 0; t < 250; t++) begin
      a = 32'h0001_0000 | (32'($urandom_range(7, 0)) << 5) | 32'($urandom_range(31, 0));
      if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
      txn(1'($urandom_range(1, 0)), a, {8{$urandom}});
    end
    idle(2);
    foreach (gold[k]) check("final_mem", mem_val(k), gold[k]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
